demux2_q: RTL and testbench

//  Queued 1-to-2 word distributor: the inverse of the 2:1 datapath select. One 16-bit

---
 rtl/demux2_q.sv | 109 ++++++++++
 tb/tb_demux2_q.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/demux2_q.sv
// Queued 1-to-2 word distributor: one source stream steered by a per-word select
// into two independent FIFOs, each with its own valid/ready consumer handshake.

module demux2_q_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic [CW-1:0]    o_count
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] r_mem;
    logic [PW-1:0]               r_wr_ptr;
    logic [PW-1:0]               r_rd_ptr;
    logic [CW-1:0]               r_count;
    logic                        w_pop;

    assign o_valid = (r_count != '0);
    assign w_pop   = o_valid & i_ready;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Pointers wrap naturally; full/empty come from the count alone.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            if (i_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (!i_push && w_pop)
                r_count <= r_count - CW'(1);
        end
    end
endmodule

module demux2_q #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_in_data,
    input  logic             i_in_sel,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    output logic [WIDTH-1:0] o_out0_data,
    output logic             o_out0_valid,
    input  logic             i_out0_ready,
    output logic [WIDTH-1:0] o_out1_data,
    output logic             o_out1_valid,
    input  logic             i_out1_ready,
    output logic [CW-1:0]    o_out0_count,
    output logic [CW-1:0]    o_out1_count
);
    localparam int NUM_Q = 2;

    logic [NUM_Q-1:0][WIDTH-1:0] w_data;
    logic [NUM_Q-1:0][CW-1:0]    w_count;
    logic [NUM_Q-1:0]            w_valid;
    logic [NUM_Q-1:0]            w_ready;
    logic [NUM_Q-1:0]            w_full;
    logic [NUM_Q-1:0]            w_push;

    assign w_ready = {i_out1_ready, i_out0_ready};

    // A full queue refuses even if it pops this cycle: no pass-through.
    assign o_in_ready = i_in_sel ? !w_full[1] : !w_full[0];

    for (genvar k = 0; k < NUM_Q; k++) begin : g_q
        assign w_full[k] = (w_count[k] == CW'(DEPTH));
        assign w_push[k] = i_in_valid & o_in_ready & (i_in_sel == k[0]);

        demux2_q_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_fifo (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_push  (w_push[k]),
            .i_data  (i_in_data),
            .i_ready (w_ready[k]),
            .o_data  (w_data[k]),
            .o_valid (w_valid[k]),
            .o_count (w_count[k])
        );
    end

    assign o_out0_data  = w_data[0];
    assign o_out1_data  = w_data[1];
    assign o_out0_valid = w_valid[0];
    assign o_out1_valid = w_valid[1];
    assign o_out0_count = w_count[0];
    assign o_out1_count = w_count[1];
endmodule

// File: tb/tb_demux2_q.sv
// Directed bench for demux2_q: reset, steering, backpressure, full refusal, wrap, reset mid-op.

module tb_demux2_q;
    localparam int WIDTH = 16;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             i_clk = 1'b0;
    logic             i_reset;
    logic [WIDTH-1:0] i_in_data;
    logic             i_in_sel;
    logic             i_in_valid;
    logic             o_in_ready;
    logic [WIDTH-1:0] o_out0_data;
    logic             o_out0_valid;
    logic             i_out0_ready;
    logic [WIDTH-1:0] o_out1_data;
    logic             o_out1_valid;
    logic             i_out1_ready;
    logic [CW-1:0]    o_out0_count;
    logic [CW-1:0]    o_out1_count;

    int checks   = 0;
    int failures = 0;

    demux2_q #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_in_data    (i_in_data),
        .i_in_sel     (i_in_sel),
        .i_in_valid   (i_in_valid),
        .o_in_ready   (o_in_ready),
        .o_out0_data  (o_out0_data),
        .o_out0_valid (o_out0_valid),
        .i_out0_ready (i_out0_ready),
        .o_out1_data  (o_out1_data),
        .o_out1_valid (o_out1_valid),
        .i_out1_ready (i_out1_ready),
        .o_out0_count (o_out0_count),
        .o_out1_count (o_out1_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Occupancy bound, sampled away from the active edge.
    always @(negedge i_clk) begin
        if (!i_reset) begin
            checks++;
            assert (o_out0_count <= CW'(DEPTH) && o_out1_count <= CW'(DEPTH)) else begin
                failures++;
                $error("FAIL count_bound observed=%0d/%0d expected<=%0d",
                       o_out0_count, o_out1_count, DEPTH);
            end
        end
    end

    initial begin
        int sent;
        int rcv;
        logic push;
        logic pop;

        i_reset = 1'b1; i_in_data = '0; i_in_sel = 1'b0; i_in_valid = 1'b0;
        i_out0_ready = 1'b0; i_out1_ready = 1'b0;

        // 1 reset
        tick(); tick();
        i_reset = 1'b0;
        #1;
        chk("rst_v0",    32'(o_out0_valid), 32'd0);
        chk("rst_v1",    32'(o_out1_valid), 32'd0);
        chk("rst_c0",    32'(o_out0_count), 32'd0);
        chk("rst_c1",    32'(o_out1_count), 32'd0);
        chk("rst_d0",    32'(o_out0_data),  32'd0);
        chk("rst_d1",    32'(o_out1_data),  32'd0);
        chk("rst_rdy0",  32'(o_in_ready),   32'd1);
        i_in_sel = 1'b1; #1;
        chk("rst_rdy1",  32'(o_in_ready),   32'd1);

        // 2 steer
        i_out0_ready = 1'b1; i_out1_ready = 1'b1;
        i_in_valid = 1'b1; i_in_sel = 1'b0; i_in_data = 16'h1234;
        tick();
        chk("st_v0", 32'(o_out0_valid), 32'd1);
        chk("st_d0", 32'(o_out0_data),  32'h1234);
        i_in_sel = 1'b1; i_in_data = 16'hABCD;
        tick();
        chk("st_c0", 32'(o_out0_count), 32'd0);
        chk("st_v1", 32'(o_out1_valid), 32'd1);
        chk("st_d1", 32'(o_out1_data),  32'hABCD);
        i_in_valid = 1'b0;
        tick();
        chk("st_c1", 32'(o_out1_count), 32'd0);

        // 3 backpressure on queue 0, queue 1 still open
        i_out0_ready = 1'b0;
        i_in_valid = 1'b1; i_in_sel = 1'b0; i_in_data = 16'h00A1;
        tick();
        i_in_data = 16'h00A2;
        tick();
        chk("bp_c0", 32'(o_out0_count), 32'd2);
        i_in_data = 16'h00A3; #1;
        chk("bp_rdy0", 32'(o_in_ready), 32'd0);
        i_in_sel = 1'b1; i_in_data = 16'h00B1; #1;
        chk("bp_rdy1", 32'(o_in_ready), 32'd1);
        tick();
        chk("bp_d1", 32'(o_out1_data), 32'h00B1);
        chk("bp_c0_hold", 32'(o_out0_count), 32'd2);
        i_in_valid = 1'b0; i_out0_ready = 1'b1;
        chk("bp_a1", 32'(o_out0_data), 32'h00A1);
        tick();
        chk("bp_a2", 32'(o_out0_data), 32'h00A2);
        chk("bp_c0_1", 32'(o_out0_count), 32'd1);
        tick();
        chk("bp_c0_0", 32'(o_out0_count), 32'd0);

        // 4 full queue refuses a push even while popping
        i_out0_ready = 1'b0;
        i_in_valid = 1'b1; i_in_sel = 1'b0; i_in_data = 16'h00C1;
        tick();
        i_in_data = 16'h00C2;
        tick();
        i_in_data = 16'h00C3; i_out0_ready = 1'b1; #1;
        chk("fu_rdy_full", 32'(o_in_ready), 32'd0);
        tick();
        chk("fu_c0",   32'(o_out0_count), 32'd1);
        chk("fu_head", 32'(o_out0_data),  32'h00C2);
        chk("fu_rdy",  32'(o_in_ready),   32'd1);
        i_in_valid = 1'b0;
        tick();
        chk("fu_drain", 32'(o_out0_count), 32'd0);

        // 5 wrap: ten words to queue 1 with a toggling consumer
        sent = 0; rcv = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (sent == 10 && rcv == 10) break;
            i_out1_ready = (cyc % 2 == 0);
            i_in_sel     = 1'b1;
            i_in_valid   = (sent < 10);
            i_in_data    = WIDTH'(sent);
            #1;
            push = i_in_valid && o_in_ready;
            pop  = o_out1_valid && i_out1_ready;
            if (pop) begin
                chk("wr_data", 32'(o_out1_data), 32'(rcv));
                rcv++;
            end
            tick();
            if (push) sent++;
        end
        chk("wr_rcv", 32'(rcv), 32'd10);
        chk("wr_empty", 32'(o_out1_count), 32'd0);
        i_in_valid = 1'b0;

        // 6 reset mid-operation
        i_out0_ready = 1'b0; i_out1_ready = 1'b0;
        i_in_valid = 1'b1; i_in_sel = 1'b0; i_in_data = 16'h00D0;
        tick();
        i_in_sel = 1'b1; i_in_data = 16'h00E0;
        tick();
        i_in_valid = 1'b0;
        chk("mr_pre_v0", 32'(o_out0_valid), 32'd1);
        chk("mr_pre_v1", 32'(o_out1_valid), 32'd1);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        chk("mr_v0", 32'(o_out0_valid), 32'd0);
        chk("mr_v1", 32'(o_out1_valid), 32'd0);
        chk("mr_c0", 32'(o_out0_count), 32'd0);
        chk("mr_c1", 32'(o_out1_count), 32'd0);
        chk("mr_d0", 32'(o_out0_data),  32'd0);
        i_out0_ready = 1'b1; i_out1_ready = 1'b1;
        i_in_valid = 1'b1; i_in_sel = 1'b0; i_in_data = 16'h5555;
        tick();
        chk("mr_post_d0", 32'(o_out0_data), 32'h5555);
        i_in_valid = 1'b0;
        tick();
        chk("mr_post_c0", 32'(o_out0_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
